// File: rtl/fifo_control_pkg.sv
// Shared definitions for the FIFO pointer/flag controller.
// The memory block and benches use the same package. It holds the depth,
// the pointer and count widths, the occupancy classification enum, and a
// helper that maps an occupancy count onto that enum.
package fifo_control_pkg;

  localparam int ADDRESS_WIDTH = 3;
  localparam int DEPTH         = 1 << ADDRESS_WIDTH;
  localparam int COUNT_WIDTH   = ADDRESS_WIDTH + 1;

  typedef logic [ADDRESS_WIDTH-1:0] ptr_t;
  typedef logic [COUNT_WIDTH-1:0]   count_t;

  localparam count_t COUNT_MAX = count_t'(DEPTH);

  // Coarse occupancy class; full/empty are decoded from this.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  function automatic occ_e occ_of(input count_t c);
    occ_e o;
    if (c == COUNT_MAX)   o = OCC_FULL;
    else if (c == '0)     o = OCC_EMPTY;
    else                  o = OCC_PARTIAL;
    return o;
  endfunction

endpackage

// File: rtl/fifo_control_if.sv
// Bundle of request, strobe and flag signals between the producer/consumer
// side and the FIFO controller.
//
// Handshake: push and pop are per-cycle requests with no ready back-channel.
// A request is accepted in the same cycle only when wr_enable or rd_enable
// is high. A request raised while full (push) or empty (pop) is dropped and
// latched into overflow_err or underflow_err. The requester retries if it
// cares.
//
// Modports:
//   master : requester side (drives push/pop/thresholds, observes the rest)
//   slave  : fifo_control (drives strobes, pointers, flags, count)
interface fifo_control_if;
  import fifo_control_pkg::*;

  logic   push;
  logic   pop;
  count_t af_thr;
  count_t ae_thr;
  logic   wr_enable;
  logic   rd_enable;
  ptr_t   wr_ptr;
  ptr_t   rd_ptr;
  logic   rd_valid;
  logic   full;
  logic   empty;
  logic   almost_full;
  logic   almost_empty;
  count_t count;
  logic   overflow_err;
  logic   underflow_err;
  occ_e   occ_state;

  modport master (
    output push, pop, af_thr, ae_thr,
    input  wr_enable, rd_enable, wr_ptr, rd_ptr, rd_valid, full, empty,
           almost_full, almost_empty, count, overflow_err, underflow_err,
           occ_state
  );

  modport slave (
    input  push, pop, af_thr, ae_thr,
    output wr_enable, rd_enable, wr_ptr, rd_ptr, rd_valid, full, empty,
           almost_full, almost_empty, count, overflow_err, underflow_err,
           occ_state
  );

endinterface

// File: rtl/fifo_control_ptr_counter.sv
// Wrapping memory-address counter. It is used once for the write pointer
// and once for the read pointer.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; clears the pointer to 0
//   en    : advance by one this cycle
//   ptr   : current address; wraps DEPTH-1 -> 0 by natural overflow
module fifo_control_ptr_counter
  import fifo_control_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  output ptr_t ptr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + ptr_t'(1);
    end
  end

endmodule

// File: rtl/fifo_control.sv
// Pointer/flag controller that sits in front of the FIFO memory.
// It turns push/pop requests into memory write/read strobes and addresses.
// It tracks occupancy and derives the full, empty and almost flags.
// It holds the sticky overflow/underflow flags and a read-data-valid strobe.
// The memory data path does not pass through here.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low. It clears the pointers, count,
//           rd_valid and the error flags.
//   bus   : slave side of fifo_control_if. It carries:
//             inputs  push, pop, af_thr, ae_thr
//             outputs wr_enable, rd_enable, wr_ptr, rd_ptr, rd_valid,
//                     full, empty, almost_full, almost_empty, count,
//                     overflow_err, underflow_err, occ_state
//           occ_state is the occupancy class and is visible for debug.
module fifo_control
  import fifo_control_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  fifo_control_if.slave bus
);

  count_t count_q;
  occ_e   occ;
  logic   full_w;
  logic   empty_w;
  logic   push_ok;
  logic   pop_ok;
  logic   rd_valid_q;
  logic   overflow_q;
  logic   underflow_q;

  // Flags come straight from the count register, so they carry no extra
  // latency.
  assign occ     = occ_of(count_q);
  assign full_w  = (occ == OCC_FULL);
  assign empty_w = (occ == OCC_EMPTY);

  // Acceptance is judged on this cycle's registered state. A push into an
  // empty FIFO does not fall through to a same-cycle pop. Strobes are
  // suppressed while reset is held so the memory is never written during
  // reset.
  assign push_ok = bus.push & ~full_w  & reset;
  assign pop_ok  = bus.pop  & ~empty_w & reset;

  fifo_control_ptr_counter u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (push_ok),
    .ptr   (bus.wr_ptr)
  );

  fifo_control_ptr_counter u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (pop_ok),
    .ptr   (bus.rd_ptr)
  );

  // Occupancy: a simultaneous accepted push and pop cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + count_t'(1);
        2'b01:   count_q <= count_q - count_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The memory registers its read data, so the data for an accepted pop
  // is valid one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop_ok;
    end
  end

  // Sticky error flags. Only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.push && full_w) overflow_q  <= 1'b1;
      if (bus.pop && empty_w) underflow_q <= 1'b1;
    end
  end

  assign bus.wr_enable     = push_ok;
  assign bus.rd_enable     = pop_ok;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.full          = full_w;
  assign bus.empty         = empty_w;
  assign bus.almost_full   = (count_q >= bus.af_thr);
  assign bus.almost_empty  = (count_q <= bus.ae_thr);
  assign bus.count         = count_q;
  assign bus.overflow_err  = overflow_q;
  assign bus.underflow_err = underflow_q;
  assign bus.occ_state     = occ;

endmodule

// File: tb/tb_fifo_control.sv
// Bench for fifo_control.
// The reference model is a queue holding the memory address of each stored
// entry. Occupancy is the queue size. The expected write and read addresses
// come from the running totals of accepted pushes and pops, modulo DEPTH.
module tb_fifo_control;
  import fifo_control_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fifo_control_if bus ();

  fifo_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- counters ----------------
  int total_cnt = 0;
  int pass_cnt  = 0;

  // ---------------- reference model ----------------
  logic [ADDRESS_WIDTH-1:0] exp_q[$];  // address of each stored entry
  int  m_pushes = 0;                   // accepted pushes since reset
  int  m_pops   = 0;                   // accepted pops since reset
  bit  m_rv     = 0;
  bit  m_ovf    = 0;
  bit  m_unf    = 0;
  bit  cur_pok;
  bit  cur_qok;

  task automatic model_reset();
    exp_q.delete();
    m_pushes = 0;
    m_pops   = 0;
    m_rv     = 0;
    m_ovf    = 0;
    m_unf    = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  // Compare every output against the model for the inputs applied now.
  task automatic check_all();
    int sz;
    sz = exp_q.size();
    cur_pok = bus.push && (sz < DEPTH) && reset;
    cur_qok = bus.pop && (sz > 0) && reset;
    chk("wr_enable", bus.wr_enable, cur_pok);
    chk("rd_enable", bus.rd_enable, cur_qok);
    chk("wr_ptr", bus.wr_ptr, m_pushes % DEPTH);
    chk("rd_ptr", bus.rd_ptr, m_pops % DEPTH);
    if (cur_qok) chk("rd_ptr_head", bus.rd_ptr, exp_q[0]);
    chk("count", bus.count, sz);
    chk("full", bus.full, sz == DEPTH);
    chk("empty", bus.empty, sz == 0);
    chk("almost_full", bus.almost_full, sz >= int'(bus.af_thr));
    chk("almost_empty", bus.almost_empty, sz <= int'(bus.ae_thr));
    chk("rd_valid", bus.rd_valid, m_rv);
    chk("overflow_err", bus.overflow_err, m_ovf);
    chk("underflow_err", bus.underflow_err, m_unf);
  endtask

  // Advance the model across a rising edge. It uses the acceptance decided
  // in check_all.
  task automatic model_edge();
    int sz;
    sz = exp_q.size();
    if (!reset) begin
      model_reset();
    end else begin
      if (bus.push && sz == DEPTH) m_ovf = 1;
      if (bus.pop && sz == 0)      m_unf = 1;
      if (cur_qok) begin
        void'(exp_q.pop_front());
        m_pops++;
      end
      if (cur_pok) begin
        exp_q.push_back(ADDRESS_WIDTH'(m_pushes % DEPTH));
        m_pushes++;
      end
      m_rv = cur_qok;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic p, input logic q);
    @(negedge clk);
    bus.push = p;
    bus.pop  = q;
    #1;
    check_all();
    @(posedge clk);
    model_edge();
  endtask

  task automatic release_reset();
    @(negedge clk);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    reset    = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.push   = 1'b1;
    bus.pop    = 1'b0;
    bus.af_thr = count_t'(6);
    bus.ae_thr = count_t'(2);
    model_reset();

    // Reset held for three clocks with push requested.
    repeat (3) step(1'b1, 1'b0);
    release_reset();

    // Fill from empty: 8 accepted, then one rejected.
    repeat (9) step(1'b1, 1'b0);
    #1 check_all();

    // Drain from full: 8 accepted, then one rejected.
    repeat (9) step(1'b0, 1'b1);
    #1 check_all();

    // Concurrent push+pop at count 4.
    repeat (4) step(1'b1, 1'b0);
    repeat (20) step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    // Push+pop at empty: only the push is accepted.
    step(1'b1, 1'b1);
    repeat (7) step(1'b1, 1'b0);
    // Push+pop at full: only the pop is accepted.
    step(1'b1, 1'b1);
    #1 check_all();

    // Randomized phase, with phases biased toward filling or draining.
    for (int i = 0; i < 240; i++) begin
      int bias;
      bias = ((i / 30) % 2 == 0) ? 75 : 25;
      bus.af_thr = count_t'($urandom_range(0, 10));
      bus.ae_thr = count_t'($urandom_range(0, 10));
      step($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias);
    end

    // Mid-operation reset at count 5 with a pop active.
    bus.af_thr = count_t'(6);
    bus.ae_thr = count_t'(2);
    @(negedge clk);
    reset = 1'b0;
    #1 model_reset();
    release_reset();
    repeat (6) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    @(negedge clk);
    bus.push = 1'b0;
    bus.pop  = 1'b1;
    #1 check_all();
    #1 reset = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    release_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    #1 check_all();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
